// File: rtl/pipe_proc_param.sv
// ---------------------------------------------------------------------------
// pipe_proc_param
//   Two-stage in-order processor core.
//   S1 decodes the instruction and captures its operands.
//   S2 executes the instruction and writes the result back.
//   A result retiring from S1 is forwarded to the instruction being accepted
//   in the same cycle. MUL holds S1 for MUL_LAT cycles. HALT freezes the core
//   until reset.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   ins_valid  instruction present on ins
//   ins_ready  core accepts an instruction this cycle
//   ins        [31:29] op, [28:24] rd, [23:19] rs1, [18:14] rs2, [13:0] imm
//   res_valid  one-cycle pulse after a register-writing retire
//   res_reg    destination register index of the retired instruction
//   res_data   value written (also reported when rd is r0)
//   halted     sticky flag, set when HALT retires
//   ret_cnt    retired-instruction count (HALT included), wraps
//   dbg_addr   debug register-file read address
//   dbg_data   combinational register-file read (no forwarding from S1)
// ---------------------------------------------------------------------------
module pipe_proc_param #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 8,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [31:0]       ins,
  output logic              res_valid,
  output logic [4:0]        res_reg,
  output logic [DATA_W-1:0] res_data,
  output logic              halted,
  output logic [CNT_W-1:0]  ret_cnt,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  // Register index width. Register fields of ins use only their low RI_W bits.
  localparam int RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  // The MUL wait counter must hold MUL_LAT-1.
  localparam int MC_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) + 1 : 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_LI   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MUL_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_t;

  // Architectural and pipeline state
  state_t             state_r;
  logic [MC_W-1:0]    mul_cnt_r;
  logic               s1_valid_r;
  logic [2:0]         s1_op_r;
  logic [RI_W-1:0]    s1_rd_r;
  logic [DATA_W-1:0]  s1_a_r;
  logic [DATA_W-1:0]  s1_b_r;
  logic [DATA_W-1:0]  rf_r [NREGS];
  logic               res_valid_r;
  logic [4:0]         res_reg_r;
  logic [DATA_W-1:0]  res_data_r;
  logic               halted_r;
  logic [CNT_W-1:0]   ret_cnt_r;

  // Incoming instruction fields
  logic [2:0]         in_op_s;
  logic [RI_W-1:0]    in_rd_s;
  logic [RI_W-1:0]    in_rs1_s;
  logic [RI_W-1:0]    in_rs2_s;
  logic [13:0]        in_imm_s;
  logic [DATA_W-1:0]  imm_ext_s;

  // Control and datapath nets
  logic               ins_ready_s;
  logic               accept_s;
  logic               retire_wr_s;
  logic               retire_halt_s;
  logic               fwd_ok_s;
  logic [DATA_W-1:0]  result_s;
  logic [DATA_W-1:0]  op_a_s;
  logic [DATA_W-1:0]  op_b_s;
  logic               unused_ok_s;

  assign in_op_s  = ins[31:29];
  assign in_rd_s  = ins[24 +: RI_W];
  assign in_rs1_s = ins[19 +: RI_W];
  assign in_rs2_s = ins[14 +: RI_W];
  assign in_imm_s = ins[13:0];
  // Sign-extend the immediate, or truncate it when DATA_W is narrower.
  assign imm_ext_s = DATA_W'($signed(in_imm_s));

  // Upper register-field and debug-address bits are unused when NREGS < 32.
  assign unused_ok_s = ^{ins, dbg_addr};

  // A MUL or HALT sitting in S1 blocks intake, and so does any non-RUN state.
  assign ins_ready_s = (state_r == ST_RUN) &&
                       !(s1_valid_r && ((s1_op_r == OP_MUL) || (s1_op_r == OP_HALT)));
  assign accept_s    = ins_valid && ins_ready_s;
  assign fwd_ok_s    = retire_wr_s && (s1_rd_r != {RI_W{1'b0}});

  // Execute stage: compute the result of the instruction held in S1.
  always_comb begin
    result_s = {DATA_W{1'b0}};
    case (s1_op_r)
      OP_ADD:  result_s = s1_a_r + s1_b_r;
      OP_SUB:  result_s = s1_a_r - s1_b_r;
      OP_AND:  result_s = s1_a_r & s1_b_r;
      OP_OR:   result_s = s1_a_r | s1_b_r;
      OP_XOR:  result_s = s1_a_r ^ s1_b_r;
      OP_MUL:  result_s = s1_a_r * s1_b_r;
      OP_LI:   result_s = s1_a_r;  // operand A carries the extended immediate
      default: result_s = {DATA_W{1'b0}};
    endcase
  end

  // Retire decision: does the S1 instruction leave the pipeline at this edge?
  always_comb begin
    retire_wr_s   = 1'b0;
    retire_halt_s = 1'b0;
    if (s1_valid_r) begin
      case (state_r)
        ST_RUN: begin
          if (s1_op_r == OP_HALT) begin
            retire_halt_s = 1'b1;
          end else if (s1_op_r == OP_MUL) begin
            // A single-cycle MUL retires straight from RUN.
            // Intake is still blocked for that cycle.
            retire_wr_s = (MUL_LAT == 1);
          end else begin
            retire_wr_s = 1'b1;
          end
        end
        ST_MUL_WAIT: begin
          retire_wr_s = (mul_cnt_r == MC_W'(1'b1));
        end
        default: begin
          retire_wr_s   = 1'b0;
          retire_halt_s = 1'b0;
        end
      endcase
    end else begin
      retire_wr_s   = 1'b0;
      retire_halt_s = 1'b0;
    end
  end

  // Operand fetch: forward the retiring S1 result over the stale RF value.
  // For LI, operand A carries the sign-extended immediate instead.
  always_comb begin
    if (in_op_s == OP_LI) begin
      op_a_s = imm_ext_s;
    end else if (fwd_ok_s && (s1_rd_r == in_rs1_s)) begin
      op_a_s = result_s;
    end else begin
      op_a_s = rf_r[in_rs1_s];
    end
    if (fwd_ok_s && (s1_rd_r == in_rs2_s)) begin
      op_b_s = result_s;
    end else begin
      op_b_s = rf_r[in_rs2_s];
    end
  end

  // S1 pipeline register: load on accept, empty on retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 3'b000;
      s1_rd_r    <= {RI_W{1'b0}};
      s1_a_r     <= {DATA_W{1'b0}};
      s1_b_r     <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= in_op_s;
      s1_rd_r    <= in_rd_s;
      s1_a_r     <= op_a_s;
      s1_b_r     <= op_b_s;
    end else if (retire_wr_s || retire_halt_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Control FSM: tracks multi-cycle MUL occupancy and the terminal HALT state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RUN;
      mul_cnt_r <= {MC_W{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          if (s1_valid_r && (s1_op_r == OP_MUL) && (MUL_LAT > 1)) begin
            state_r   <= ST_MUL_WAIT;
            mul_cnt_r <= MC_W'(MUL_LAT - 1);
          end else if (s1_valid_r && (s1_op_r == OP_HALT)) begin
            state_r <= ST_HALT;
          end
        end
        ST_MUL_WAIT: begin
          if (mul_cnt_r == MC_W'(1'b1)) begin
            state_r   <= ST_RUN;
            mul_cnt_r <= {MC_W{1'b0}};
          end else begin
            mul_cnt_r <= mul_cnt_r - MC_W'(1'b1);
          end
        end
        ST_HALT: begin
          state_r <= ST_HALT;
        end
        default: begin
          state_r   <= ST_RUN;
          mul_cnt_r <= {MC_W{1'b0}};
        end
      endcase
    end
  end

  // Register file write-back. r0 is never written, so it always reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= {DATA_W{1'b0}};
      end
    end else if (fwd_ok_s) begin
      rf_r[s1_rd_r] <= result_s;
    end
  end

  // Retire reporting: result pulse, sticky halt flag, retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_reg_r   <= 5'd0;
      res_data_r  <= {DATA_W{1'b0}};
      halted_r    <= 1'b0;
      ret_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      res_valid_r <= retire_wr_s;
      if (retire_wr_s) begin
        res_reg_r  <= 5'(s1_rd_r);
        res_data_r <= result_s;
      end
      if (retire_halt_s) begin
        halted_r <= 1'b1;
      end
      if (retire_wr_s || retire_halt_s) begin
        ret_cnt_r <= ret_cnt_r + CNT_W'(1'b1);
      end
    end
  end

  assign ins_ready = ins_ready_s;
  assign res_valid = res_valid_r;
  assign res_reg   = res_reg_r;
  assign res_data  = res_data_r;
  assign halted    = halted_r;
  assign ret_cnt   = ret_cnt_r;
  assign dbg_data  = rf_r[dbg_addr[RI_W-1:0]];

endmodule

// File: tb/tb_pipe_proc_param.sv
module tb_pipe_proc_param;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_LI   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ins_valid = 1'b0;
  logic [31:0] ins = 32'd0;
  logic [4:0]  dbg_addr = 5'd0;

  logic        ins_ready, res_valid, halted;
  logic [4:0]  res_reg;
  logic [31:0] res_data, dbg_data;
  logic [15:0] ret_cnt;

  logic        ins_ready_c4, res_valid_c4, halted_c4;
  logic [4:0]  res_reg_c4;
  logic [31:0] res_data_c4, dbg_data_c4;
  logic [3:0]  ret_cnt_c4;

  pipe_proc_param u_dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
    .res_valid(res_valid), .res_reg(res_reg), .res_data(res_data), .halted(halted),
    .ret_cnt(ret_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Same stimulus; only the narrow retire counter is observed.
  pipe_proc_param #(.CNT_W(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready_c4), .ins(ins),
    .res_valid(res_valid_c4), .res_reg(res_reg_c4), .res_data(res_data_c4),
    .halted(halted_c4), .ret_cnt(ret_cnt_c4), .dbg_addr(dbg_addr), .dbg_data(dbg_data_c4)
  );

  always #5 clk = ~clk;

  // Reference model: sequential architectural execution
  typedef struct packed {
    logic [4:0]  rg;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] m_rf [8];
  logic [31:0] m_retired;
  logic        m_halted;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [13:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic model_exec(input logic [31:0] i);
    logic [2:0]  op;
    logic [31:0] a, b, r;
    int          rd;
    op = i[31:29];
    rd = int'(i[26:24]);
    a  = m_rf[i[21:19]];
    b  = m_rf[i[16:14]];
    r  = 32'd0;
    m_retired = m_retired + 32'd1;
    if (op == OP_HALT) begin
      m_halted = 1'b1;
    end else begin
      case (op)
        OP_ADD:  r = a + b;
        OP_SUB:  r = a - b;
        OP_AND:  r = a & b;
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        OP_MUL:  r = a * b;
        default: r = {{18{i[13]}}, i[13:0]};
      endcase
      if (rd != 0) m_rf[rd] = r;
      exp_q.push_back('{rg: 5'(rd), d: r});
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (exp_q.size() == 0) begin
        chk("res_unexpected", {63'd0, res_valid}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_reg", {59'd0, res_reg}, {59'd0, mon_e.rg});
        chk("res_data", {32'd0, res_data}, {32'd0, mon_e.d});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    ins_valid = 1'b0;
    exp_q.delete();
    for (int r = 0; r < 8; r++) m_rf[r] = 32'd0;
    m_retired = 32'd0;
    m_halted  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] i, input bit gaps, output int waited);
    bit rdy;
    bit done;
    int n;
    waited = 0;
    rdy = 1'b0;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        ins_valid = 1'b0;
        ins = $urandom;
        @(posedge clk);
        #1;
      end
    end
    ins = i;
    ins_valid = 1'b1;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      rdy = ins_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 40) begin
          chk("accept_timeout", {63'd0, rdy}, 64'd1);
          done = 1'b1;
        end
      end
    end
    ins_valid = 1'b0;
    if (rdy) model_exec(i);
  endtask

  task automatic drain(input int n);
    ins_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rf(input string tag);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 5'(r);
      #1;
      chk($sformatf("%s_dbg_r%0d", tag, r), {32'd0, dbg_data}, {32'd0, m_rf[r]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_ret_cnt"}, {48'd0, ret_cnt}, {48'd0, m_retired[15:0]});
    chk({tag, "_ret_cnt_c4"}, {60'd0, ret_cnt_c4}, {60'd0, m_retired[3:0]});
    chk({tag, "_halted"}, {63'd0, halted}, {63'd0, m_halted});
    chk_rf(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ins_ready"}, {63'd0, ins_ready}, 64'd1);
    chk({tag, "_res_valid"}, {63'd0, res_valid}, 64'd0);
    chk({tag, "_res_reg"}, {59'd0, res_reg}, 64'd0);
    chk({tag, "_res_data"}, {32'd0, res_data}, 64'd0);
    chk({tag, "_halted"}, {63'd0, halted}, 64'd0);
    chk({tag, "_ret_cnt"}, {48'd0, ret_cnt}, 64'd0);
    chk({tag, "_ret_cnt_c4"}, {60'd0, ret_cnt_c4}, 64'd0);
  endtask

  initial begin
    int w;
    int hi;
    logic [2:0] op;

    // T1: reset state
    do_reset();
    chk_reset_outputs("t1");
    chk_rf("t1");

    // T2: LI r1,5; LI r2,-3; ADD r3,r1,r2 back-to-back via forwarding
    send(enc(OP_LI, 5'd1, 5'd0, 5'd0, 14'd5), 1'b0, w);
    send(enc(OP_LI, 5'd2, 5'd0, 5'd0, 14'h3FFD), 1'b0, w);
    send(enc(OP_ADD, 5'd3, 5'd1, 5'd2, 14'd0), 1'b0, w);
    chk("t2_no_stall", 64'(w), 64'd0);
    drain(3);
    chk("t2_ret_cnt_is_3", {48'd0, ret_cnt}, 64'd3);
    dbg_addr = 5'd3;
    #1;
    chk("t2_r3_is_2", {32'd0, dbg_data}, 64'd2);
    chk_state("t2");

    // T3: MUL r4,r1,r1 then ADD r5,r4,r1: three stall cycles
    send(enc(OP_MUL, 5'd4, 5'd1, 5'd1, 14'd0), 1'b0, w);
    send(enc(OP_ADD, 5'd5, 5'd4, 5'd1, 14'd0), 1'b0, w);
    chk("t3_stall_cycles", 64'(w), 64'd3);
    drain(3);
    dbg_addr = 5'd4;
    #1;
    chk("t3_r4_is_25", {32'd0, dbg_data}, 64'd25);
    dbg_addr = 5'd5;
    #1;
    chk("t3_r5_is_30", {32'd0, dbg_data}, 64'd30);
    chk_state("t3");

    // T4: seed registers, then a 64-instruction XOR/SUB stream with gaps
    for (int r = 1; r < 8; r++) begin
      send(enc(OP_LI, 5'(r), 5'd0, 5'd0, 14'($urandom)), 1'b1, w);
    end
    for (int k = 0; k < 64; k++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_XOR : OP_SUB;
      send(enc(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 14'($urandom)), 1'b1, w);
    end
    drain(4);
    chk_state("t4");

    // Mixed stream over every non-HALT opcode
    for (int k = 0; k < 48; k++) begin
      op = 3'($urandom_range(0, 6));
      send(enc(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 14'($urandom)), 1'b1, w);
    end
    drain(6);
    chk_state("mix");

    // T5: HALT blocks all further instructions
    send(enc(OP_HALT, 5'd0, 5'd0, 5'd0, 14'd0), 1'b0, w);
    ins = enc(OP_LI, 5'd1, 5'd0, 5'd0, 14'd99);
    ins_valid = 1'b1;
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (ins_ready) hi++;
      @(posedge clk);
      #1;
    end
    ins_valid = 1'b0;
    chk("t5_ready_high_cycles", 64'(hi), 64'd0);
    chk("t5_halted_set", {63'd0, halted}, 64'd1);
    chk_state("t5");
    do_reset();
    chk_reset_outputs("t5_rst");

    // T6a: reset in the middle of a MUL discards it
    send(enc(OP_LI, 5'd6, 5'd0, 5'd0, 14'd7), 1'b0, w);
    send(enc(OP_MUL, 5'd7, 5'd6, 5'd6, 14'd0), 1'b0, w);
    @(posedge clk);
    #1;
    do_reset();
    chk_reset_outputs("t6_midmul");
    drain(6);
    chk_state("t6_midmul");

    // T6b: 16 retires wrap the 4-bit counter to 0, one more gives 1
    for (int k = 0; k < 16; k++) begin
      send(enc(OP_LI, 5'($urandom_range(1, 7)), 5'd0, 5'd0, 14'($urandom)), 1'b0, w);
    end
    drain(3);
    chk("t6_wrap_c4_zero", {60'd0, ret_cnt_c4}, 64'd0);
    chk("t6_wide_16", {48'd0, ret_cnt}, 64'd16);
    send(enc(OP_LI, 5'd0, 5'd0, 5'd0, 14'd1), 1'b0, w);
    drain(3);
    chk("t6_wrap_c4_one", {60'd0, ret_cnt_c4}, 64'd1);
    chk_state("t6_wrap");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
